// File: rtl/sensor_pkg.sv
// -----------------------------------------------------------------------------
// sensor_pkg
// Shared definitions for the sensor record arbiter (sensor_rr_arb) and its
// combinational picker (rr_pick).
//   SENS_DW      record width in bits
//   SENS_NCH     default number of receive channels
//   SENS_IW      default channel index width
//   arb_state_t  output handshake state (IDLE / SEND)
//   sens_rec_t   one sensor record
// -----------------------------------------------------------------------------
package sensor_pkg;

    localparam int SENS_DW  = 40;
    localparam int SENS_NCH = 4;
    localparam int SENS_IW  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

    typedef logic [SENS_DW-1:0] sens_rec_t;

endpackage : sensor_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational channel picker. Default build: round-robin, the search starts
// at (last+1) mod NCH and wraps. With FIXED_PRIO_EN defined: fixed priority,
// the lowest pending index wins and last is ignored.
// Ports:
//   pend    [NCH]  channels with a record waiting
//   last    [IW]   index of the previous winner
//   gnt_oh  [NCH]  one-hot winner (zero when nothing is pending)
//   gnt_idx [IW]   winner index (zero when nothing is pending)
//   any            at least one channel pending
// Configuration macro: FIXED_PRIO_EN
// -----------------------------------------------------------------------------
module rr_pick
    import sensor_pkg::*;
#(
    parameter int NCH = SENS_NCH,
    parameter int IW  = SENS_IW
) (
    input  logic [NCH-1:0] pend,
    input  logic [IW-1:0]  last,
    output logic [NCH-1:0] gnt_oh,
    output logic [IW-1:0]  gnt_idx,
    output logic           any
);

`ifdef FIXED_PRIO_EN
    // The pointer has no meaning in fixed-priority mode.
    logic w_unused_last;
    assign w_unused_last = ^last;
`endif

    // Each pending channel gets a distance from the search start; the
    // smallest distance wins. Round-robin measures from last+1, fixed
    // priority measures from channel 0.
    always_comb begin
        int w_dist;
        int w_best;
        // NOTE: every output gets a default before the loop so no path through
        // this block can leave a value unassigned and infer a latch.
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = |pend;
        w_best  = NCH;
        w_dist  = 0;
        for (int j = 0; j < NCH; j++) begin
`ifdef FIXED_PRIO_EN
            w_dist = j;
`else
            w_dist = (j + 2 * NCH - 1 - int'(last)) % NCH;
`endif
            if (pend[j] && (w_dist < w_best)) begin
                w_best    = w_dist;
                gnt_oh    = '0;
                gnt_oh[j] = 1'b1;
                gnt_idx   = IW'(j);
            end
        end
    end

endmodule : rr_pick

// File: rtl/sensor_rr_arb.sv
// -----------------------------------------------------------------------------
// sensor_rr_arb
// Shares one sensor-record write port between NCH receive channels. Each
// strobed record lands in a one-deep per-channel slot; pending slots are
// granted to the output in round-robin order over a valid/ready handshake.
// A record overwritten before it was granted raises a sticky ovf bit.
// Ports:
//   sys_clk  in   system clock, rising edge
//   sys_rst  in   asynchronous active-low reset
//   ch_d     in   channel records, channel k at [k*DW +: DW]
//   ch_f     in   per-channel one-cycle record strobe
//   out_d    out  granted record
//   out_id   out  channel index owning out_d
//   out_f    out  out_d/out_id valid
//   out_rdy  in   downstream accepts when out_f && out_rdy
//   ovf      out  sticky per-channel overwrite flags
//   ovf_clr  in   one-cycle pulse clearing all ovf bits
// Configuration macro: FIXED_PRIO_EN (fixed-priority picker, see rr_pick)
// -----------------------------------------------------------------------------
module sensor_rr_arb
    import sensor_pkg::*;
#(
    parameter int NCH = SENS_NCH,
    parameter int DW  = SENS_DW,
    parameter int IW  = SENS_IW
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [NCH*DW-1:0] ch_d,
    input  logic [NCH-1:0]    ch_f,
    output logic [DW-1:0]     out_d,
    output logic [IW-1:0]     out_id,
    output logic              out_f,
    input  logic              out_rdy,
    output logic [NCH-1:0]    ovf,
    input  logic              ovf_clr
);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [DW-1:0]   r_slot [NCH];
    logic [NCH-1:0]  r_pend;
    logic [NCH-1:0]  r_ovf;
    logic [IW-1:0]   r_last;
    logic [DW-1:0]   r_out_d;
    logic [IW-1:0]   r_out_id;

    logic [NCH-1:0]  w_gnt_oh;
    logic [IW-1:0]   w_gnt_idx;
    logic            w_any;
    logic            w_load;
    logic [NCH-1:0]  w_grant;
    logic [NCH-1:0]  w_ovf_set;
    logic [DW-1:0]   w_gnt_d;

    rr_pick #(
        .NCH (NCH),
        .IW  (IW)
    ) u_pick (
        .pend    (r_pend),
        .last    (r_last),
        .gnt_oh  (w_gnt_oh),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // Next state and load decision. A new winner is loaded from IDLE or on
    // the accepting edge in SEND, which gives back-to-back transfers.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_rdy) begin
                    if (w_any) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_grant = w_load ? w_gnt_oh : '0;

    // A strobe on a slot that is pending and not leaving this cycle loses
    // the older record. A strobe on the granted slot simply refills it.
    assign w_ovf_set = ch_f & r_pend & ~w_grant;

    // One-hot mux of the winning slot.
    always_comb begin
        w_gnt_d = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_gnt_oh[k]) begin
                w_gnt_d = w_gnt_d | r_slot[k];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_pend   <= '0;
            r_ovf    <= '0;
            r_last   <= IW'(NCH - 1);
            r_out_d  <= '0;
            r_out_id <= '0;
        end else begin
            r_pend <= (r_pend & ~w_grant) | ch_f;
            // Set wins over a simultaneous clear.
            r_ovf  <= (r_ovf & ~{NCH{ovf_clr}}) | w_ovf_set;
            if (w_load) begin
                r_last   <= w_gnt_idx;
                r_out_d  <= w_gnt_d;
                r_out_id <= w_gnt_idx;
            end
        end
    end

    // NOTE: slot storage is not reset; pend qualifies it, so reset only has
    // to clear pend and the record bits stay plain enable flops.
    always_ff @(posedge sys_clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (ch_f[k]) begin
                r_slot[k] <= ch_d[k*DW +: DW];
            end
        end
    end

    assign out_f  = (r_state == SEND);
    assign out_d  = r_out_d;
    assign out_id = r_out_id;
    assign ovf    = r_ovf;

endmodule : sensor_rr_arb
